// File: rtl/rans_pkg.sv
// Shared types, constants and helpers for the rANS byte packer.
package rans_pkg;
  localparam int SYM_W_DEF      = 8;
  localparam int WORD_BYTES_DEF = 4;

  typedef logic [SYM_W_DEF-1:0] byte_t;

  typedef enum logic {PK_RUN, PK_FLUSH} pack_state_e;

  localparam logic [1:0] VLD_NONE = 2'd0;
  localparam logic [1:0] VLD_ONE  = 2'd1;
  localparam logic [1:0] VLD_TWO  = 2'd2;

  // Contiguous byte-enable mask with the low `fill` bits set; callers cast to their width.
  function automatic logic [63:0] keep_mask(input int unsigned fill);
    return (64'd1 << fill) - 64'd1;
  endfunction
endpackage

// File: rtl/rans_axis_out_reg.sv
// One-entry AXI4-Stream output register; free when empty or draining this cycle.
module rans_axis_out_reg #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          set_last_i,
  input  logic [DW-1:0] data_i,
  input  logic [KW-1:0] keep_i,
  input  logic          last_i,
  input  logic          m_tready_i,
  output logic [DW-1:0] m_tdata_o,
  output logic [KW-1:0] m_tkeep_o,
  output logic          m_tlast_o,
  output logic          m_tvalid_o,
  output logic          free_o
);
  logic [DW-1:0] data_q, data_d;
  logic [KW-1:0] keep_q, keep_d;
  logic          last_q, last_d;
  logic          valid_q, valid_d;

  always_comb begin
    free_o  = !valid_q || m_tready_i;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      keep_d  = keep_i;
      last_d  = last_i;
      valid_d = 1'b1;
    end else if (free_o) begin
      valid_d = 1'b0;
    end else if (set_last_i) begin
      // Stream closed with nothing staged: the held beat becomes the final one.
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign m_tdata_o  = data_q;
  assign m_tkeep_o  = keep_q;
  assign m_tlast_o  = last_q;
  assign m_tvalid_o = valid_q;
endmodule

// File: rtl/rans_byte_packer.sv
// Packs 0/1/2 encoder bytes per cycle little-endian into AXI-S beats, with flush/tlast.
module rans_byte_packer
  import rans_pkg::*;
#(
  parameter int SYMBOL_WIDTH = SYM_W_DEF,
  parameter int WORD_BYTES   = WORD_BYTES_DEF
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [2*SYMBOL_WIDTH-1:0]           enc_i,
  input  logic [1:0]                          valid_i,
  output logic                                ready_o,
  input  logic                                flush_i,
  output logic [WORD_BYTES*SYMBOL_WIDTH-1:0]  m_tdata_o,
  output logic [WORD_BYTES-1:0]               m_tkeep_o,
  output logic                                m_tlast_o,
  output logic                                m_tvalid_o,
  input  logic                                m_tready_i,
  output logic [31:0]                         stream_bytes_o
);
  localparam int              FW      = $clog2(WORD_BYTES);
  localparam logic [FW:0]     WB      = (FW+1)'(WORD_BYTES);
  localparam logic [FW-1:0]   RDY_MAX = FW'(WORD_BYTES-3);

  typedef logic [WORD_BYTES-1:0][SYMBOL_WIDTH-1:0] word_t;

  pack_state_e   state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  word_t         stage_q, stage_d;
  logic [31:0]   cnt_q, cnt_d;

  logic                                    out_free, load, set_last, load_last;
  word_t                                   load_data;
  logic [WORD_BYTES-1:0]                   load_keep;
  logic [1:0]                              n, n_acc;
  logic [FW:0]                             sum, pos0, pos1;
  logic                                    accept, flush_acc, word_done, hs_last;
  logic [2*WORD_BYTES-1:0][SYMBOL_WIDTH-1:0] wbuf;
  logic [32:0]                             cnt_inc;

  always_comb begin
    // An illegal count of 3 folds into 2.
    n         = (valid_i == VLD_NONE) ? 2'd0 : (valid_i == VLD_ONE) ? 2'd1 : VLD_TWO;
    ready_o   = (state_q == PK_RUN) && ((fill_q <= RDY_MAX) || out_free);
    accept    = ready_o && (valid_i != VLD_NONE);
    flush_acc = ready_o && flush_i;
    n_acc     = accept ? n : 2'd0;
    sum       = {1'b0, fill_q} + {{(FW-1){1'b0}}, n_acc};
    pos0      = {1'b0, fill_q};
    pos1      = pos0 + (FW+1)'(1);

    // Double-width scratch: the upper half catches the overflow byte of a completed word.
    wbuf                   = '0;
    wbuf[WORD_BYTES-1:0]   = stage_q;
    if (n_acc != 2'd0) wbuf[pos0] = enc_i[SYMBOL_WIDTH-1:0];
    if (n_acc == VLD_TWO) wbuf[pos1] = enc_i[2*SYMBOL_WIDTH-1:SYMBOL_WIDTH];
    word_done = (sum >= WB);

    state_d   = state_q;
    fill_d    = fill_q;
    stage_d   = stage_q;
    load      = 1'b0;
    set_last  = 1'b0;
    load_data = wbuf[WORD_BYTES-1:0];
    load_keep = '1;
    load_last = 1'b0;

    if (state_q == PK_RUN) begin
      if (word_done) begin
        load    = 1'b1;
        stage_d = wbuf[2*WORD_BYTES-1:WORD_BYTES];
        fill_d  = FW'(sum - WB);
      end else begin
        stage_d = wbuf[WORD_BYTES-1:0];
        fill_d  = sum[FW-1:0];
      end
      if (flush_acc) begin
        if (fill_d != '0 || !(word_done || !out_free)) state_d = PK_FLUSH;
        else if (word_done) load_last = 1'b1;
        else set_last = 1'b1;
      end
    end else if (out_free) begin
      load      = 1'b1;
      load_keep = WORD_BYTES'(keep_mask(32'(fill_q)));
      for (int i = 0; i < WORD_BYTES; i++)
        load_data[i] = load_keep[i] ? stage_q[i] : '0;
      load_last = 1'b1;
      stage_d   = '0;
      fill_d    = '0;
      state_d   = PK_RUN;
    end

    hs_last = m_tvalid_o && m_tready_i && m_tlast_o;
    cnt_inc = {1'b0, cnt_q} + 33'(n_acc);
    if (hs_last)         cnt_d = 32'(n_acc);
    else if (cnt_inc[32]) cnt_d = '1;
    else                 cnt_d = cnt_inc[31:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PK_RUN;
      fill_q  <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  rans_axis_out_reg #(.DW(WORD_BYTES*SYMBOL_WIDTH), .KW(WORD_BYTES)) u_out (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .set_last_i (set_last),
    .data_i     (load_data),
    .keep_i     (load_keep),
    .last_i     (load_last),
    .m_tready_i (m_tready_i),
    .m_tdata_o  (m_tdata_o),
    .m_tkeep_o  (m_tkeep_o),
    .m_tlast_o  (m_tlast_o),
    .m_tvalid_o (m_tvalid_o),
    .free_o     (out_free)
  );

  assign stream_bytes_o = cnt_q;

  a_valid_legal: assert property (@(posedge clk_i) disable iff (rst_i) valid_i != 2'd3);
endmodule

// File: tb/tb_rans_byte_packer.sv
// Directed + random bench for rans_byte_packer against a byte-queue reference model.
module tb_rans_byte_packer;
  import rans_pkg::*;
  localparam int W  = 4;
  localparam int SW = 8;

  typedef struct {
    logic [W*SW-1:0] data;
    logic [W-1:0]    keep;
    logic            last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst, rdy, flush, tlast, tvalid, tready;
  logic [15:0]   enc;
  logic [1:0]    vld;
  logic [W*SW-1:0] tdata;
  logic [W-1:0]  tkeep;
  logic [31:0]   sbytes;

  always #5 clk = ~clk;

  rans_byte_packer #(.SYMBOL_WIDTH(SW), .WORD_BYTES(W)) dut (
    .clk_i(clk), .rst_i(rst), .enc_i(enc), .valid_i(vld), .ready_o(rdy),
    .flush_i(flush), .m_tdata_o(tdata), .m_tkeep_o(tkeep), .m_tlast_o(tlast),
    .m_tvalid_o(tvalid), .m_tready_i(tready), .stream_bytes_o(sbytes));

  int            vec = 0, errs = 0;
  beat_t         exp_q[$];
  byte_t         part_q[$];
  logic [31:0]   beat_log[$];
  logic [31:0]   mcnt;
  logic          prev_hold, acc, ready_low, seen_last;
  logic [31:0]   prev_data;
  logic [W-1:0]  prev_keep, seen_keep;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Staged bytes (empty allowed) become one expected beat.
  task automatic push_part(input logic last);
    beat_t b;
    b.data = '0; b.keep = '0; b.last = last;
    foreach (part_q[i]) begin
      b.data[i*SW +: SW] = part_q[i];
      b.keep[i] = 1'b1;
    end
    exp_q.push_back(b);
    part_q.delete();
  endtask

  task automatic check();
    int    nb;
    logic  hs_last;
    longint s;
    beat_t b;
    acc = 1'b0;
    hs_last = 1'b0;
    if (rst) begin
      exp_q.delete(); part_q.delete(); mcnt = '0; prev_hold = 1'b0;
      return;
    end
    chk("stream_bytes", 64'(sbytes), 64'(mcnt));
    if (prev_hold) begin
      chk("hold_valid", 64'(tvalid), 64'(1));
      chk("hold_data", 64'(tdata), 64'(prev_data));
      chk("hold_keep", 64'(tkeep), 64'(prev_keep));
    end
    if (tvalid && tready) begin
      if (exp_q.size() == 0) chk("spurious_beat", 64'(tvalid), 64'(0));
      else begin
        b = exp_q.pop_front();
        chk("beat_data", 64'(tdata), 64'(b.data));
        chk("beat_keep", 64'(tkeep), 64'(b.keep));
        chk("beat_last", 64'(tlast), 64'(b.last));
        beat_log.push_back(tdata);
        seen_keep = tkeep; seen_last = tlast;
        hs_last = b.last;
      end
    end
    nb = (vld == 2'd0) ? 0 : (vld == 2'd1) ? 1 : 2;
    if (!rdy) ready_low = 1'b1;
    if (!rdy) nb = 0;
    if (rdy && (nb > 0 || flush)) acc = 1'b1;
    for (int k = 0; k < nb; k++) begin
      part_q.push_back(enc[k*SW +: SW]);
      if (part_q.size() == W) push_part(1'b0);
    end
    if (rdy && flush) begin
      if (part_q.size() > 0 || exp_q.size() == 0) push_part(1'b1);
      else exp_q[exp_q.size()-1].last = 1'b1;
    end
    if (hs_last) mcnt = 32'(nb);
    else begin
      s = longint'(mcnt) + longint'(nb);
      mcnt = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
    end
    prev_hold = tvalid && !tready;
    prev_data = tdata;
    prev_keep = tkeep;
  endtask

  task automatic tick();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vld = 2'd0; flush = 1'b0;
    repeat (n) tick();
  endtask

  task automatic offer(input logic [1:0] v, input logic [15:0] d, input logic f);
    int t = 0;
    vld = v; enc = d; flush = f;
    do begin tick(); t++; end while (!acc && t < 64);
    chk("offer_accepted", 64'(acc), 64'(1));
    vld = 2'd0; flush = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_tvalid", 64'(tvalid), 64'(0));
    chk("rst_tdata", 64'(tdata), 64'(0));
    chk("rst_tkeep", 64'(tkeep), 64'(0));
    chk("rst_tlast", 64'(tlast), 64'(0));
    chk("rst_sbytes", 64'(sbytes), 64'(0));
    chk("rst_ready", 64'(rdy), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, idx;
    rst = 1'b1; vld = 2'd0; enc = '0; flush = 1'b0; tready = 1'b1;
    prev_hold = 1'b0; mcnt = '0; ready_low = 1'b0;
    @(posedge clk); #1;
    reset_dut();

    // Two full words at two bytes per cycle.
    base = beat_log.size(); ready_low = 1'b0;
    offer(2'd2, 16'h0201, 1'b0); offer(2'd2, 16'h0403, 1'b0);
    offer(2'd2, 16'h0605, 1'b0); offer(2'd2, 16'h0807, 1'b0);
    idle(3);
    chk("t1_ready_held", 64'(ready_low), 64'(0));
    chk("t1_sbytes", 64'(sbytes), 64'(8));
    chk("t1_nbeats", 64'(beat_log.size() - base), 64'(2));
    chk("t1_beat0", 64'(beat_log[base]), 64'h04030201);
    chk("t1_beat1", 64'(beat_log[base+1]), 64'h08070605);

    // Partial word closed by flush.
    base = beat_log.size();
    offer(2'd1, 16'h00AA, 1'b0); offer(2'd2, 16'hCCBB, 1'b0);
    offer(2'd2, 16'hEEDD, 1'b0); offer(2'd0, 16'h0000, 1'b1);
    idle(4);
    chk("t2_nbeats", 64'(beat_log.size() - base), 64'(2));
    chk("t2_beat0", 64'(beat_log[base]), 64'hDDCCBBAA);
    chk("t2_beat1", 64'(beat_log[base+1]), 64'h000000EE);
    chk("t2_keep", 64'(seen_keep), 64'h1);
    chk("t2_last", 64'(seen_last), 64'(1));
    chk("t2_sbytes_clear", 64'(sbytes), 64'(0));

    // Flush on the completing cycle tags that word; no null beat.
    base = beat_log.size();
    offer(2'd2, 16'h2211, 1'b0); offer(2'd2, 16'h4433, 1'b1);
    idle(4);
    chk("t3_nbeats", 64'(beat_log.size() - base), 64'(1));
    chk("t3_beat", 64'(beat_log[base]), 64'h44332211);
    chk("t3_keep", 64'(seen_keep), 64'hF);
    chk("t3_last", 64'(seen_last), 64'(1));

    // Mid-stream reset discards, then an empty stream gives a null beat.
    offer(2'd2, 16'h6655, 1'b0);
    reset_dut();
    base = beat_log.size();
    offer(2'd0, 16'h0000, 1'b1);
    idle(4);
    chk("t4_nbeats", 64'(beat_log.size() - base), 64'(1));
    chk("t4_data", 64'(beat_log[base]), 64'(0));
    chk("t4_keep", 64'(seen_keep), 64'(0));
    chk("t4_last", 64'(seen_last), 64'(1));

    // Downstream stall while 12 bytes are offered.
    tready = 1'b0; ready_low = 1'b0; idx = 0;
    for (int c = 0; c < 60 && idx < 6; c++) begin
      vld = 2'd2;
      enc = {8'(8'h31 + 2*idx), 8'(8'h30 + 2*idx)};
      if (c == 15) tready = 1'b1;
      tick();
      if (acc) idx++;
    end
    chk("t5_all_taken", 64'(idx), 64'(6));
    chk("t5_ready_dropped", 64'(ready_low), 64'(1));
    tready = 1'b1;
    offer(2'd0, 16'h0000, 1'b1);
    idle(4);

    // Random traffic, backpressure and flushes.
    for (int c = 0; c < 1500; c++) begin
      vld    = 2'($urandom_range(0, 2));
      enc    = 16'($urandom);
      flush  = ($urandom_range(0, 15) == 0);
      tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    tready = 1'b1;
    offer(2'd0, 16'h0000, 1'b1);
    idle(8);
    chk("drain_beats", 64'(exp_q.size()), 64'(0));
    chk("drain_bytes", 64'(part_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/rans_byte_packer.md
Name: rans_byte_packer

Overview:
- Downstream of the rANS encoder core: consumes its 0/1/2-byte-per-cycle renormalisation output (enc/valid) and packs the bytes little-endian into WORD_BYTES-wide AXI4-Stream beats for the Zynq DMA.
- Drives the encoder's ready input as backpressure.
- A flush request closes the stream: the partial word is emitted with tkeep and tlast asserted.

Parameters:
- SYMBOL_WIDTH, 8, byte width; enc_i is 2*SYMBOL_WIDTH bits wide.
- WORD_BYTES, 4, bytes per output beat; power of two, >= 4.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- enc_i  in  2*SYMBOL_WIDTH  encoder bytes; enc_i[7:0] is the older byte
- valid_i  in  2  byte count this cycle: 0, 1 (enc_i[7:0] only) or 2; 3 is illegal
- ready_o  out  1  packer can take up to 2 bytes this cycle; wired to the encoder's ready input
- flush_i  in  1  end-of-stream pulse; bytes presented in the same cycle belong to the stream
- m_tdata_o  out  WORD_BYTES*SYMBOL_WIDTH  output beat; first byte in [7:0]
- m_tkeep_o  out  WORD_BYTES  byte enables, contiguous from bit 0
- m_tlast_o  out  1  last beat of the stream
- m_tvalid_o  out  1  AXI-S valid
- m_tready_i  in  1  AXI-S ready
- stream_bytes_o  out  32  bytes accepted in the current stream

Behaviour:
- Reset: all outputs 0 except ready_o, which is 1 in the cycle after reset deasserts. Fill count 0; state RUN.
- Bytes are accepted only when valid_i!=0 and ready_o=1; otherwise valid_i is ignored.
- Datapath: staging register of WORD_BYTES bytes plus fill count (0..WORD_BYTES-1), and one output register (o_valid).
- Output register is free when !o_valid or (o_valid & m_tready_i).
- ready_o, state RUN:
  - ready_o = (fill <= WORD_BYTES-3) or output register free.
  - Must not depend combinationally on valid_i.
  - ready_o = 0 in state FLUSH.
- Accepted bytes are written at positions fill and fill+1.
- Word completion (fill+n >= WORD_BYTES):
  - The full word moves to the output register with tkeep all ones and tlast 0.
  - Any overflow byte lands at staging position 0.
  - New fill = fill+n-WORD_BYTES.
- Latency: the byte completing a word appears on m_tdata_o the next cycle.
- Output register is held stable while m_tvalid_o & !m_tready_i (AXI rule).
- flush_i accepted (ready_o=1), after merging same-cycle bytes:
  - Resulting fill>0, or no word is pending: go to FLUSH.
  - Resulting fill==0 and the same cycle's completion produced a word, or a word is already pending: that pending/new word gets tlast=1; stay RUN.
- State FLUSH: when the output register is free, emit the staged partial word.
  - tkeep = (1<<fill)-1; unused data bytes are 0; tlast=1.
  - fill becomes 0; return to RUN.
  - fill==0 in FLUSH (empty stream): emit a null beat, tkeep=0, tdata=0, tlast=1.
- stream_bytes_o:
  - Increments by n on every accept; saturates at 2^32-1.
  - Clears to 0 on the cycle after the tlast beat's handshake.
  - If new bytes are accepted in that same cycle, it loads n instead.
- valid_i==3 is treated as 2 (assertion in sim).
- flush_i while ready_o=0 is ignored; the source holds it.
- Reset mid-stream discards staged and pending data, with no tlast emitted.
- Simultaneous output handshake and word completion: the new word replaces the old one in the same cycle with no bubble, giving full throughput at 2 bytes/cycle.

Decomposition:
- Package rans_pkg:
  - byte_t (logic [SYMBOL_WIDTH-1:0])
  - enum pack_state_e {PK_RUN, PK_FLUSH}
  - valid encoding constants VLD_NONE=0, VLD_ONE=1, VLD_TWO=2
  - function keep_mask(fill) returning WORD_BYTES-bit mask
- One sub-module, rans_axis_out_reg: one-entry AXI-S output register (data/keep/last/valid), load/free handshake.

Test Plan:
- Reset, then valid_i=2 for 4 cycles with bytes 01..08 and m_tready_i=1 -> beats 0x04030201 and 0x08070605, tkeep=F, tlast=0; ready_o stays 1; stream_bytes_o=8.
- valid_i pattern 1,2,2 (bytes AA, BB CC, DD EE) then flush_i -> beat 0xDDCCBBAA tkeep=F tlast=0, then beat 0x000000EE tkeep=1 tlast=1; stream_bytes_o returns to 0 after the tlast handshake.
- 4 bytes 11..44 then flush_i on the cycle the word completes -> single beat 0x44332211 tkeep=F tlast=1, with no null beat.
- flush_i with no bytes since reset -> one beat tkeep=0 tlast=1.
- m_tready_i=0 while 12 bytes are offered at valid_i=2 -> ready_o drops to 0 once the output is pending and fill>=2; no byte is lost or duplicated; data held stable; release gives the in-order byte stream.
- Random valid_i in {0,1,2}, random m_tready_i, random flushes -> scoreboard byte order, tkeep contiguity and tlast placement match the reference model; stream_bytes_o matches per-stream counts.
